// File: rtl/quat_pkg.sv
// Shared types and widths for the quaternion multiplier arbiter slice.
package quat_pkg;

   localparam int unsigned QW     = 16;
   localparam int unsigned PW     = 32;
   localparam int unsigned QIN_W  = 4 * QW;
   localparam int unsigned QOUT_W = 4 * PW;

   typedef struct packed {
      logic signed [QW-1:0] a3;
      logic signed [QW-1:0] a2;
      logic signed [QW-1:0] a1;
      logic signed [QW-1:0] a0;
   } quat_in_t;

   typedef struct packed {
      logic signed [PW-1:0] q3;
      logic signed [PW-1:0] q2;
      logic signed [PW-1:0] q1;
      logic signed [PW-1:0] q0;
   } quat_out_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   // Signed 16x16 product widened to the 32-bit result lane.
   function automatic logic signed [PW-1:0] smul(input logic signed [QW-1:0] x,
                                                 input logic signed [QW-1:0] y);
      return PW'(x) * PW'(y);
   endfunction

endpackage

// File: rtl/quaternion_multiplication.sv
// Hamilton product q = a * b with a MUL_LAT-deep output pipeline; sums wrap at 32 bits.
module quaternion_multiplication
   import quat_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [QW-1:0] a0,
   input  logic signed [QW-1:0] a1,
   input  logic signed [QW-1:0] a2,
   input  logic signed [QW-1:0] a3,
   input  logic signed [QW-1:0] b0,
   input  logic signed [QW-1:0] b1,
   input  logic signed [QW-1:0] b2,
   input  logic signed [QW-1:0] b3,
   output logic signed [PW-1:0] q0,
   output logic signed [PW-1:0] q1,
   output logic signed [PW-1:0] q2,
   output logic signed [PW-1:0] q3
);

   quat_out_t prod;
   quat_out_t pipe_q [MUL_LAT];

   always_comb begin
      prod    = '0;
      prod.q0 = smul(a0, b0) - smul(a1, b1) - smul(a2, b2) - smul(a3, b3);
      prod.q1 = smul(a0, b1) + smul(a1, b0) + smul(a2, b3) - smul(a3, b2);
      prod.q2 = smul(a0, b2) - smul(a1, b3) + smul(a2, b0) + smul(a3, b1);
      prod.q3 = smul(a0, b3) + smul(a1, b2) - smul(a2, b1) + smul(a3, b0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= prod;
         for (int unsigned i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q0 = pipe_q[MUL_LAT-1].q0;
   assign q1 = pipe_q[MUL_LAT-1].q1;
   assign q2 = pipe_q[MUL_LAT-1].q2;
   assign q3 = pipe_q[MUL_LAT-1].q3;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i wins.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   always_comb begin
      logic [IW-1:0] j;
      logic          found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         j = IW'((32'(ptr_i) + k) % NREQ);
         if (!found && req_i[j]) begin
            found    = 1'b1;
            idx_o    = j;
            gnt_o[j] = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/quat_mul_arbiter.sv
// Shares one quaternion multiplier among NREQ requesters, one product in flight,
// round-robin grant with valid/ready handshakes on both request and response.
module quat_mul_arbiter
   import quat_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*QIN_W-1:0]     req_a,
   input  logic [NREQ*QIN_W-1:0]     req_b,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [QOUT_W-1:0]         rsp_q,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(MUL_LAT + 1);

   state_e          state_q;
   quat_in_t        opa_q, opb_q;
   quat_out_t       rsp_q_q;
   logic [IW-1:0]   grant_q, rr_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic            busy_q;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gidx;
   logic            gany;
   quat_in_t        a_arr [NREQ];
   quat_in_t        b_arr [NREQ];
   logic signed [PW-1:0] mq0, mq1, mq2, mq3;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         a_arr[i] = quat_in_t'(req_a[i*QIN_W +: QIN_W]);
         b_arr[i] = quat_in_t'(req_b[i*QIN_W +: QIN_W]);
      end
   end

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx),
      .any_o (gany)
   );

   quaternion_multiplication #(.MUL_LAT(MUL_LAT)) u_mul (
      .clk (clk),
      .rst (~rst),
      .a0  (opa_q.a0), .a1 (opa_q.a1), .a2 (opa_q.a2), .a3 (opa_q.a3),
      .b0  (opb_q.a0), .b1 (opb_q.a1), .b2 (opb_q.a2), .b3 (opb_q.a3),
      .q0  (mq0), .q1 (mq1), .q2 (mq2), .q3 (mq3)
   );

   // Accept is combinational so the request handshake closes in the grant cycle.
   assign req_ready = (rst && state_q == IDLE) ? gnt : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         rsp_q_q     <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= IW'(NREQ - 1);
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gany) begin
                  opa_q   <= a_arr[gidx];
                  opb_q   <= b_arr[gidx];
                  grant_q <= gidx;
                  cnt_q   <= CW'(MUL_LAT);
                  busy_q  <= 1'b1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  rsp_q_q     <= quat_out_t'({mq3, mq2, mq1, mq0});
                  rsp_valid_q <= NREQ'(1) << grant_q;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready[grant_q]) begin
                  rr_ptr_q    <= grant_q;
                  rsp_valid_q <= '0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_q     = rsp_q_q;
   assign grant_id  = grant_q;
   assign busy      = busy_q;

endmodule
